// File: rtl/nxk_board_game.sv
// N x N two-player board game engine with K-in-a-row win detection.
// Moves arrive on a valid/ready handshake. Each move is checked for range,
// occupancy and turn order, then a sequential scan walks outward from the
// last placed cell in four directions to detect a win or a draw.
module nxk_board_game #(
  parameter int         N     = 3,
  parameter int         K     = 3,
  parameter logic [1:0] FIRST = 2'b01,
  localparam int        CELLS = N * N,
  localparam int        PW    = $clog2(CELLS),
  localparam int        CW    = $clog2(CELLS + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               new_game,
  input  logic               move_valid,
  input  logic [1:0]         move_player,
  input  logic [PW-1:0]      move_pos,
  output logic               move_ready,
  output logic               move_accept,
  output logic               move_reject,
  output logic [2*CELLS-1:0] board,
  output logic [1:0]         turn,
  output logic [CW-1:0]      move_count,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam int             RCW     = $clog2(N);
  localparam logic [PW:0]    CELLS_P = (PW + 1)'(CELLS);
  localparam logic [CW-1:0]  CELLS_C = CW'(CELLS);
  localparam logic [RCW-1:0] EDGE    = RCW'(N - 1);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t state_q, state_d;

  logic [2*CELLS-1:0] board_q, board_d;
  logic [1:0]         turn_q, turn_d;
  logic [CW-1:0]      count_q, count_d;
  logic [1:0]         winner_q, winner_d;
  logic               accept_q, accept_d;
  logic               reject_q, reject_d;
  logic               ready_q, ready_d;
  logic               over_q, over_d;

  // scan context: mover, origin cell, walk cursor, direction, side, run length
  logic [1:0]     mover_q, mover_d;
  logic [RCW-1:0] last_r_q, last_r_d, last_c_q, last_c_d;
  logic [RCW-1:0] cur_r_q, cur_r_d, cur_c_q, cur_c_d;
  logic [1:0]     dir_q, dir_d;
  logic           neg_q, neg_d;
  logic [3:0]     run_q, run_d;

  logic           fwd_r_inc, fwd_c_inc, fwd_c_dec;
  logic           step_r_dn, step_r_up, step_c_rt, step_c_lf;
  logic           in_board, step_ok, run_hits_k, scan_end, board_full;
  logic [RCW-1:0] nr, nc;
  logic [PW-1:0]  nxt_pos;
  logic [1:0]     nxt_cell, tgt_cell;
  logic           pos_ok, legal;
  logic [RCW-1:0] move_r, move_c;

  // Forward step of the current direction (rows only ever increase forward).
  always_comb begin
    fwd_r_inc = 1'b0;
    fwd_c_inc = 1'b0;
    fwd_c_dec = 1'b0;
    unique case (dir_q)
      2'd0:    fwd_c_inc = 1'b1;
      2'd1:    fwd_r_inc = 1'b1;
      2'd2:    begin fwd_r_inc = 1'b1; fwd_c_inc = 1'b1; end
      default: begin fwd_r_inc = 1'b1; fwd_c_dec = 1'b1; end
    endcase
  end

  assign step_r_dn = fwd_r_inc & ~neg_q;
  assign step_r_up = fwd_r_inc & neg_q;
  assign step_c_rt = neg_q ? fwd_c_dec : fwd_c_inc;
  assign step_c_lf = neg_q ? fwd_c_inc : fwd_c_dec;

  // Edge checks on row/column keep a walk from wrapping into the next row.
  assign in_board = !(step_r_dn && cur_r_q == EDGE) && !(step_r_up && cur_r_q == '0) &&
                    !(step_c_rt && cur_c_q == EDGE) && !(step_c_lf && cur_c_q == '0);

  assign nr = step_r_dn ? cur_r_q + RCW'(1) : (step_r_up ? cur_r_q - RCW'(1) : cur_r_q);
  assign nc = step_c_rt ? cur_c_q + RCW'(1) : (step_c_lf ? cur_c_q - RCW'(1) : cur_c_q);
  assign nxt_pos  = PW'(32'(nr) * N + 32'(nc));
  assign nxt_cell = board_q[{nxt_pos, 1'b0} +: 2];

  assign step_ok    = in_board && (nxt_cell == mover_q);
  assign run_hits_k = step_ok && ((run_q + 4'd1) == 4'(K));
  assign scan_end   = !step_ok && neg_q && (dir_q == 2'd3);
  assign board_full = (count_q == CELLS_C);

  assign pos_ok   = {1'b0, move_pos} < CELLS_P;
  assign tgt_cell = board_q[{move_pos, 1'b0} +: 2];
  assign legal    = pos_ok && (tgt_cell == 2'b00) && (move_player == turn_q);
  assign move_r   = RCW'(32'(move_pos) / N);
  assign move_c   = RCW'(32'(move_pos) % N);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; new_game wins over any move in the same cycle.
  always_comb begin
    state_d = state_q;
    if (new_game) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (move_valid && legal) state_d = CHECK;
        CHECK: begin
          if (run_hits_k)    state_d = DONE;
          else if (scan_end) state_d = board_full ? DONE : IDLE;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake/status outputs decoded from the upcoming state, then registered.
  always_comb begin
    ready_d = (state_d == IDLE);
    over_d  = (state_d == DONE);
  end

  // Board update, move validation and one scan step per CHECK cycle.
  always_comb begin
    board_d  = board_q;
    turn_d   = turn_q;
    count_d  = count_q;
    winner_d = winner_q;
    accept_d = 1'b0;
    reject_d = 1'b0;
    mover_d  = mover_q;
    last_r_d = last_r_q;
    last_c_d = last_c_q;
    cur_r_d  = cur_r_q;
    cur_c_d  = cur_c_q;
    dir_d    = dir_q;
    neg_d    = neg_q;
    run_d    = run_q;
    if (new_game) begin
      board_d  = '0;
      turn_d   = FIRST;
      count_d  = '0;
      winner_d = 2'b00;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (move_valid) begin
            if (legal) begin
              board_d[{move_pos, 1'b0} +: 2] = move_player;
              count_d  = count_q + CW'(1);
              accept_d = 1'b1;
              mover_d  = move_player;
              last_r_d = move_r;
              last_c_d = move_c;
              cur_r_d  = move_r;
              cur_c_d  = move_c;
              dir_d    = 2'd0;
              neg_d    = 1'b0;
              run_d    = 4'd1;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
        CHECK: begin
          if (step_ok) begin
            run_d   = run_q + 4'd1;
            cur_r_d = nr;
            cur_c_d = nc;
            if (run_hits_k) winner_d = mover_q;
          end else if (!neg_q) begin
            neg_d   = 1'b1;
            cur_r_d = last_r_q;
            cur_c_d = last_c_q;
          end else if (dir_q != 2'd3) begin
            dir_d   = dir_q + 2'd1;
            neg_d   = 1'b0;
            run_d   = 4'd1;
            cur_r_d = last_r_q;
            cur_c_d = last_c_q;
          end else if (board_full) begin
            winner_d = 2'b11;
          end else begin
            turn_d = ~turn_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      board_q  <= '0;
      turn_q   <= FIRST;
      count_q  <= '0;
      winner_q <= 2'b00;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      ready_q  <= 1'b1;
      over_q   <= 1'b0;
      mover_q  <= '0;
      last_r_q <= '0;
      last_c_q <= '0;
      cur_r_q  <= '0;
      cur_c_q  <= '0;
      dir_q    <= '0;
      neg_q    <= 1'b0;
      run_q    <= '0;
    end else begin
      board_q  <= board_d;
      turn_q   <= turn_d;
      count_q  <= count_d;
      winner_q <= winner_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
      ready_q  <= ready_d;
      over_q   <= over_d;
      mover_q  <= mover_d;
      last_r_q <= last_r_d;
      last_c_q <= last_c_d;
      cur_r_q  <= cur_r_d;
      cur_c_q  <= cur_c_d;
      dir_q    <= dir_d;
      neg_q    <= neg_d;
      run_q    <= run_d;
    end
  end

  assign board       = board_q;
  assign turn        = turn_q;
  assign move_count  = count_q;
  assign winner      = winner_q;
  assign move_accept = accept_q;
  assign move_reject = reject_q;
  assign move_ready  = ready_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_nxk_board_game.sv
// Bench for nxk_board_game: three instances (3x3/K3, 5x5/K4, 3x3/K3 with the
// computer moving first) checked every cycle against a rule-level game model.
module tb_nxk_board_game;

  localparam int NN [3] = '{3, 5, 3};
  localparam int KK [3] = '{3, 4, 3};
  localparam int FF [3] = '{1, 1, 2};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       ng  [3];
  logic       mv  [3];
  logic [1:0] mp  [3];
  logic [4:0] mpos[3];

  logic       rdy [3];
  logic       acc [3];
  logic       rej [3];
  logic       over[3];
  logic [1:0] trn [3];
  logic [1:0] win [3];

  logic [17:0]  board0, board2;
  logic [49:0]  board1;
  logic [3:0]   cnt0, cnt2;
  logic [4:0]   cnt1;
  logic [127:0] brd[3];
  logic [6:0]   cnt[3];

  assign brd[0] = 128'(board0);
  assign brd[1] = 128'(board1);
  assign brd[2] = 128'(board2);
  assign cnt[0] = 7'(cnt0);
  assign cnt[1] = 7'(cnt1);
  assign cnt[2] = 7'(cnt2);

  nxk_board_game #(.N(3), .K(3), .FIRST(2'b01)) u0 (
    .clock(clock), .reset(reset), .new_game(ng[0]), .move_valid(mv[0]),
    .move_player(mp[0]), .move_pos(mpos[0][3:0]), .move_ready(rdy[0]),
    .move_accept(acc[0]), .move_reject(rej[0]), .board(board0), .turn(trn[0]),
    .move_count(cnt0), .game_over(over[0]), .winner(win[0]));

  nxk_board_game #(.N(5), .K(4), .FIRST(2'b01)) u1 (
    .clock(clock), .reset(reset), .new_game(ng[1]), .move_valid(mv[1]),
    .move_player(mp[1]), .move_pos(mpos[1]), .move_ready(rdy[1]),
    .move_accept(acc[1]), .move_reject(rej[1]), .board(board1), .turn(trn[1]),
    .move_count(cnt1), .game_over(over[1]), .winner(win[1]));

  nxk_board_game #(.N(3), .K(3), .FIRST(2'b10)) u2 (
    .clock(clock), .reset(reset), .new_game(ng[2]), .move_valid(mv[2]),
    .move_player(mp[2]), .move_pos(mpos[2][3:0]), .move_ready(rdy[2]),
    .move_accept(acc[2]), .move_reject(rej[2]), .board(board2), .turn(trn[2]),
    .move_count(cnt2), .game_over(over[2]), .winner(win[2]));

  // Game model: board contents, whose turn, result; resolved when the scan ends.
  int mb[3][64];
  int mturn[3], mcount[3], mwin[3], mpend[3], cyc[3];
  bit mchk[3], mdone[3], macc[3], mrej[3], seen[3];

  int total = 0;
  int bad   = 0;

  function automatic bit wins(int i, int pos, int side);
    int dr[4] = '{0, 1, 1, 1};
    int dc[4] = '{1, 0, 1, -1};
    int n, r0, c0, r, c, run, s;
    n  = NN[i];
    r0 = pos / n;
    c0 = pos % n;
    for (int d = 0; d < 4; d++) begin
      run = 1;
      for (int sg = 0; sg < 2; sg++) begin
        s = (sg == 0) ? 1 : -1;
        r = r0 + s * dr[d];
        c = c0 + s * dc[d];
        while (r >= 0 && r < n && c >= 0 && c < n && mb[i][r*n+c] == side) begin
          run++;
          r += s * dr[d];
          c += s * dc[d];
        end
      end
      if (run >= KK[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic mclear(int i);
    for (int c = 0; c < 64; c++) mb[i][c] = 0;
    mturn[i] = FF[i]; mcount[i] = 0; mwin[i] = 0; mpend[i] = 0;
    mchk[i] = 1'b0; mdone[i] = 1'b0; macc[i] = 1'b0; mrej[i] = 1'b0;
  endtask

  task automatic model_step();
    int p, s;
    for (int i = 0; i < 3; i++) begin
      macc[i] = 1'b0;
      mrej[i] = 1'b0;
      if (reset || ng[i]) begin
        mclear(i);
      end else begin
        if (mchk[i] && seen[i]) begin
          if (mpend[i] != 0) begin mwin[i] = mpend[i]; mdone[i] = 1'b1; end
          else mturn[i] = 3 - mturn[i];
          mchk[i] = 1'b0;
        end
        if (!mchk[i] && !mdone[i] && mv[i]) begin
          p = int'(mpos[i]);
          s = int'(mp[i]);
          if (p < NN[i] * NN[i] && mb[i][p] == 0 && s == mturn[i]) begin
            mb[i][p] = s;
            mcount[i]++;
            macc[i] = 1'b1;
            mchk[i] = 1'b1;
            mpend[i] = wins(i, p, s) ? s : ((mcount[i] == NN[i] * NN[i]) ? 3 : 0);
          end else begin
            mrej[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic chk(string nm, int i, int a, int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s[u%0d] actual=%0d required=%0d", nm, i, a, e);
    end
  endtask

  task automatic chkv(string nm, int i, logic [127:0] a, logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s[u%0d] actual=%h required=%h", nm, i, a, e);
    end
  endtask

  task automatic compare_all();
    logic [127:0] eb;
    for (int i = 0; i < 3; i++) begin
      eb = '0;
      for (int c = 0; c < NN[i] * NN[i]; c++) eb[2*c +: 2] = 2'(mb[i][c]);
      chkv("board", i, brd[i], eb);
      chk("move_count", i, int'(cnt[i]), mcount[i]);
      chk("move_accept", i, int'(acc[i]), int'(macc[i]));
      chk("move_reject", i, int'(rej[i]), int'(mrej[i]));
      if (!mchk[i]) begin
        cyc[i] = 0;
        chk("move_ready", i, int'(rdy[i]), int'(!mdone[i]));
        chk("game_over", i, int'(over[i]), int'(mdone[i]));
        chk("turn", i, int'(trn[i]), mturn[i]);
        chk("winner", i, int'(win[i]), mwin[i]);
      end else begin
        cyc[i]++;
        chk("check_len_ok", i, int'(cyc[i] <= 8 * (KK[i] - 1) + 2), 1);
      end
      seen[i] = rdy[i] || over[i];
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  // e: 0 = no pulse, 1 = accept, 2 = reject
  task automatic move(int i, int side, int pos, int e);
    mv[i] = 1'b1; mp[i] = 2'(side); mpos[i] = 5'(pos);
    tick();
    mv[i] = 1'b0;
    chk("pulse_acc", i, int'(acc[i]), int'(e == 1));
    chk("pulse_rej", i, int'(rej[i]), int'(e == 2));
  endtask

  task automatic settle(int i);
    for (int n = 0; n < 40 && mchk[i]; n++) tick();
    chk("scan_finished", i, int'(mchk[i]), 0);
  endtask

  task automatic play(int i, int side, int pos);
    move(i, side, pos, 1);
    settle(i);
  endtask

  task automatic newg(int i);
    ng[i] = 1'b1;
    tick();
    ng[i] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [127:0] b;
    int order[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ng[i] = 1'b0; mv[i] = 1'b0; mp[i] = 2'b00; mpos[i] = '0;
      seen[i] = 1'b0; cyc[i] = 0;
      mclear(i);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();

    // reset values pinned by hand
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", i, int'(rdy[i]), 1);
      chk("rst_count", i, int'(cnt[i]), 0);
      chk("rst_winner", i, int'(win[i]), 0);
      chk("rst_over", i, int'(over[i]), 0);
    end
    chk("rst_turn", 0, int'(trn[0]), 1);
    chk("rst_turn", 1, int'(trn[1]), 1);
    chk("rst_turn", 2, int'(trn[2]), 2);

    // anti-diagonal win 2-4-6 by player
    play(0, 1, 4); play(0, 2, 0); play(0, 1, 2); play(0, 2, 1); play(0, 1, 6);
    b = brd[0];
    chk("win_over", 0, int'(over[0]), 1);
    chk("win_winner", 0, int'(win[0]), 1);
    chk("win_cell2", 0, int'(b[5:4]), 1);
    chk("win_cell4", 0, int'(b[9:8]), 1);
    chk("win_cell6", 0, int'(b[13:12]), 1);
    chk("win_count", 0, int'(cnt[0]), 5);
    move(0, 1, 7, 0);
    newg(0);

    // illegal moves: occupied, out of range, wrong turn
    play(0, 1, 4);
    move(0, 2, 4, 2);
    b = brd[0];
    chk("occ_cell4", 0, int'(b[9:8]), 1);
    chk("occ_turn", 0, int'(trn[0]), 2);
    move(0, 2, 9, 2);
    move(0, 1, 0, 2);
    newg(0);

    // full board with no line -> draw
    for (int k = 0; k < 9; k++) play(0, (k % 2 == 0) ? 1 : 2, order[k]);
    chk("draw_winner", 0, int'(win[0]), 3);
    chk("draw_over", 0, int'(over[0]), 1);
    chk("draw_count", 0, int'(cnt[0]), 9);
    newg(0);

    // new_game together with a move mid-game: move dropped
    play(0, 1, 4); play(0, 2, 0);
    ng[0] = 1'b1; mv[0] = 1'b1; mp[0] = 2'b01; mpos[0] = 5'd8;
    tick();
    ng[0] = 1'b0; mv[0] = 1'b0;
    b = brd[0];
    chk("ng_board", 0, int'(b[17:0]), 0);
    chk("ng_turn", 0, int'(trn[0]), 1);
    chk("ng_acc", 0, int'(acc[0]), 0);
    chk("ng_rej", 0, int'(rej[0]), 0);

    // 5x5, K=4: row win, then a run that would only exist by row wrap
    play(1, 1, 0); play(1, 2, 5); play(1, 1, 1); play(1, 2, 6);
    play(1, 1, 2); play(1, 2, 7); play(1, 1, 3);
    chk("k4_winner", 1, int'(win[1]), 1);
    chk("k4_over", 1, int'(over[1]), 1);
    newg(1);
    play(1, 1, 3); play(1, 2, 10); play(1, 1, 4); play(1, 2, 11); play(1, 1, 5);
    chk("wrap_winner", 1, int'(win[1]), 0);
    chk("wrap_ready", 1, int'(rdy[1]), 1);
    chk("wrap_turn", 1, int'(trn[1]), 2);

    // reset in the middle of a scan
    move(1, 2, 12, 1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) mclear(i);
    tick();
    chk("rstchk_board0", 1, int'(brd[1] == '0), 1);
    chk("rstchk_ready", 1, int'(rdy[1]), 1);
    chk("rstchk_acc", 1, int'(acc[1]), 0);
    chk("rstchk_count", 1, int'(cnt[1]), 0);
    chk("rstchk_turn", 1, int'(trn[1]), 1);
    reset = 1'b0;
    tick();
    chk("post_rst_acc", 1, int'(acc[1]), 0);
    chk("post_rst_rej", 1, int'(rej[1]), 0);

    // computer moves first
    chk("first_turn", 2, int'(trn[2]), 2);
    move(2, 1, 0, 2);
    play(2, 2, 0);
    chk("first_after", 2, int'(trn[2]), 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nxk_board_game.md
Name: nxk_board_game

Overview:
- Parametrised two-player N×N board game engine with K-in-a-row win detection. It generalises the 3×3 game block.
- Accepts moves through a valid/ready handshake and validates each one: range, occupancy and turn order.
- Stores the board and runs a sequential win scan from the last placed cell.
- Reports win or draw. It sits between the player/computer input logic and the LED/display logic.

Parameters:
- N, 3, board side length; legal range 3..8.
- K, 3, stones in a row needed to win; 3 ≤ K ≤ N.
- FIRST, 2'b01, code of the side that moves first after reset or new_game; 2'b01 or 2'b10 only.
- Derived localparams: CELLS = N*N; PW = $clog2(CELLS); CW = $clog2(CELLS+1).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears board, FSM and all outputs
- new_game  in  1  synchronous clear to the same state as reset
- move_valid  in  1  move request
- move_player  in  2  side making the move: 01 = player, 10 = computer
- move_pos  in  PW  cell index, row*N+col
- move_ready  out  1  block can take a move this cycle
- move_accept  out  1  one-cycle pulse: last move was legal and written
- move_reject  out  1  one-cycle pulse: last move was illegal, board unchanged
- board  out  2*CELLS  cell i is board[2i+1:2i]; 00 empty, 01 player, 10 computer
- turn  out  2  side expected to move next
- move_count  out  CW  number of occupied cells
- game_over  out  1  high in DONE
- winner  out  2  00 none/in progress, 01 player, 10 computer, 11 draw

Behaviour:
- Reset values:
  - board = 0, turn = FIRST, move_count = 0, winner = 00.
  - game_over = 0, move_accept = 0, move_reject = 0, move_ready = 1.
  - FSM in IDLE.
- States: IDLE, CHECK, DONE. All outputs are registered.
- IDLE:
  - move_ready = 1.
  - A move is taken on a clock edge where move_valid = 1.
  - The move is illegal if move_pos ≥ CELLS, or the target cell is non-empty, or move_player ≠ turn.
  - Illegal move: move_reject = 1 for the next cycle; board, turn and count are unchanged; stay in IDLE.
  - Legal move: the cell is written with move_player on that edge, move_count increments, move_accept = 1 for the next cycle, and the FSM goes to CHECK.
  - The last position and side are latched for the scan.
- CHECK:
  - move_ready = 0; move_valid is ignored.
  - Scans four directions in order: horizontal, vertical, diagonal (down-right), anti-diagonal (down-left).
  - Per direction:
    - run = 1.
    - Walk the positive side one cell per cycle, while the cell is in-board, equals the mover, and run < K.
    - Then walk the negative side the same way.
    - Row/column edge checks prevent wrap-around between rows.
  - As soon as run reaches K: winner = mover, go to DONE.
  - Otherwise, after all four directions:
    - if move_count == CELLS: winner = 11, go to DONE;
    - else turn toggles (01↔10), go to IDLE.
  - CHECK lasts at most 8*(K-1)+1 cycles.
- DONE:
  - game_over = 1, winner held, move_ready = 0.
  - move_valid is ignored: no accept or reject pulses.
  - Only reset or new_game leaves DONE.
- new_game:
  - Honoured in every state and takes priority over a move_valid in the same cycle; that move is dropped with no pulse.
  - Next cycle equals the post-reset state.
- Reset asserted mid-CHECK or mid-game: immediate clear; no pulse is emitted after release.
- Winning move that also fills the board: the result is a win (winner = mover), not a draw.
- move_accept and move_reject are never high together. At most one pulse per taken move.

Test Plan:
- Defaults; after reset: P(01)@4, C(10)@0, P@2, C@1, P@6 → five accepts; after last CHECK, game_over = 1, winner = 01, board cells 2, 4, 6 = 01, move_count = 5; a further move_valid gives no pulse.
- Defaults; P@4 then C@4 → reject pulse, board[9:8] = 01, turn stays 10; C@9 (out of range) → reject; P@0 while turn = 10 → reject.
- Defaults; fill the board in the order 0, 1, 2, 4, 3, 5, 7, 6, 8 with alternating sides → no win; after the 9th move winner = 11, game_over = 1, move_count = 9.
- N=5, K=4; P@0, 1, 2 and C@5, 6, 7, then P@3 → win 01. Separately, P@3, 4 and P@5 (next row) → no win (row wrap not counted); move_ready rises within 25 cycles of each accept.
- new_game and move_valid asserted together during IDLE mid-game → board = 0, turn = FIRST, no pulse; reset pulsed during CHECK → all outputs at reset values next cycle.
- FIRST = 10 → after reset turn = 10; first move by 01 → reject, by 10 → accept.
